// File: rtl/mem_probe_if.sv
// Read-request/finish handshake between the probe and the memory read port.
interface mem_probe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_fin;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, rd_addr, input rd_fin, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_fin, rd_data);
endinterface

// File: rtl/mem_probe.sv
// Memory inspection engine: walks a region word by word (single-step or burst)
// from debounced board keys, with backward stepping, reload and read watchdog.
module mem_probe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int STRIDE    = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              key_fwd,
  input  logic              key_back,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_init,
  mem_probe_if.master       bus,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(STRIDE);
  localparam logic [7:0]        BLEN  = 8'(BURST_LEN);
  localparam logic [15:0]       TLAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  // [0] first sync flop, [1] second sync flop, [2] previous synced value
  logic [2:0]  fwd_sync, back_sync;
  logic        fwd_pulse, back_pulse;
  logic [7:0]  remaining;
  logic [15:0] wait_cnt;
  logic        do_load, do_start, do_back, do_fin, do_to;

  // Keys are active-low: a press is a 1->0 transition of the synced level.
  assign fwd_pulse  = fwd_sync[2]  & ~fwd_sync[1];
  assign back_pulse = back_sync[2] & ~back_sync[1];
  assign busy       = (state != IDLE);

  // Key synchronisers and edge-detect history, preset to "released".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_sync  <= 3'b111;
      back_sync <= 3'b111;
    end else begin
      fwd_sync  <= {fwd_sync[1:0], key_fwd};
      back_sync <= {back_sync[1:0], key_back};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and one-hot action strobes for the datapath.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_start  = 1'b0;
    do_back   = 1'b0;
    do_fin    = 1'b0;
    do_to     = 1'b0;
    case (state)
      IDLE: if (enable) begin
        if (addr_load)       do_load = 1'b1;
        else if (fwd_pulse) begin
          do_start  = 1'b1;
          state_nxt = REQ;
        end
        else if (back_pulse) do_back = 1'b1;
      end
      REQ: begin
        // A finish on the last allowed cycle beats the watchdog.
        if (bus.rd_fin) begin
          do_fin    = 1'b1;
          state_nxt = (remaining > 8'd1 && enable) ? GAP : IDLE;
        end else if (wait_cnt == TLAST) begin
          do_to     = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP:     state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address walk, request line, captured data, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd_req  <= 1'b0;
      bus.rd_addr <= addr_init;
      dout        <= '0;
      dout_valid  <= 1'b0;
      timeout_err <= 1'b0;
      rd_count    <= '0;
      remaining   <= '0;
      wait_cnt    <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (do_load) begin
        bus.rd_addr <= addr_init;
        timeout_err <= 1'b0;
      end
      if (do_back) bus.rd_addr <= bus.rd_addr - STEP;
      if (do_start) begin
        remaining   <= mode ? BLEN : 8'd1;
        timeout_err <= 1'b0;
        bus.rd_req  <= 1'b1;
        wait_cnt    <= '0;
      end
      if (do_fin) begin
        dout        <= bus.rd_data;
        dout_valid  <= 1'b1;
        bus.rd_addr <= bus.rd_addr + STEP;
        rd_count    <= rd_count + 1'b1;
        remaining   <= remaining - 8'd1;
        bus.rd_req  <= 1'b0;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (do_to) begin
        bus.rd_req  <= 1'b0;
        timeout_err <= 1'b1;
      end
      // Re-request after the single low cycle between burst words.
      if (state == GAP) begin
        bus.rd_req <= 1'b1;
        wait_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_probe.sv
// Bench for mem_probe: memory responder, request monitor and a word-level
// model of where the probe should be reading and what it should show.
module tb_mem_probe;
  localparam int TOUT = 16;
  localparam int BLEN = 4;

  logic        clk, reset, enable, mode, key_fwd, key_back, addr_load;
  logic [31:0] addr_init, dout, rd_count32;
  logic        dout_valid, busy, timeout_err;
  logic [15:0] rd_count;

  mem_probe_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_probe #(.DATA_W(32), .ADDR_W(32), .STRIDE(4), .BURST_LEN(BLEN),
              .TIMEOUT(TOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .key_fwd(key_fwd), .key_back(key_back), .addr_load(addr_load),
    .addr_init(addr_init), .bus(bus), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .timeout_err(timeout_err), .rd_count(rd_count));

  assign rd_count32 = {16'd0, rd_count};

  initial clk = 0;
  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  // responder controls
  int          lat = 0, lat_cnt;
  bit          resp_off = 0, resp_fixed = 0;
  logic [31:0] fixed_data = 0, xor_key = 0;

  // monitor records
  logic [31:0] req_log[$];
  int          gap_log[$], hi_log[$];
  int          dv_cnt, stab_err, hi_run, lo_run;
  logic        prev_req;
  logic [31:0] cur_addr;

  // model state
  logic [31:0] m_addr, m_dout;
  int          m_count;

  // Memory: finishes `lat` samples after seeing a request.
  initial begin
    bus.rd_fin = 0; bus.rd_data = 0; lat_cnt = 0;
    forever begin
      @(posedge clk); #1;
      bus.rd_fin = 0;
      if (bus.rd_req === 1'b1 && !resp_off) begin
        if (lat_cnt >= lat) begin
          bus.rd_fin  = 1;
          bus.rd_data = resp_fixed ? fixed_data : (bus.rd_addr ^ xor_key);
          lat_cnt = 0;
        end else lat_cnt++;
      end else lat_cnt = 0;
    end
  end

  // Monitor: request addresses, low gaps, high lengths, data pulses.
  initial begin
    prev_req = 0; hi_run = 0; lo_run = 0; dv_cnt = 0; stab_err = 0; cur_addr = 0;
    forever begin
      @(posedge clk); #2;
      if (dout_valid === 1'b1) dv_cnt++;
      if (bus.rd_req === 1'b1) begin
        if (!prev_req) begin
          req_log.push_back(bus.rd_addr); gap_log.push_back(lo_run);
          cur_addr = bus.rd_addr; hi_run = 0;
        end else if (bus.rd_addr !== cur_addr) stab_err++;
        hi_run++;
      end else begin
        if (prev_req) begin hi_log.push_back(hi_run); lo_run = 0; end
        lo_run++;
      end
      prev_req = (bus.rd_req === 1'b1);
    end
  end

  task automatic clear_logs();
    req_log.delete(); gap_log.delete(); hi_log.delete();
  endtask

  task automatic load_addr(input logic [31:0] a);
    @(posedge clk); #1 addr_init = a; addr_load = 1;
    @(posedge clk); #1 addr_load = 0;
    m_addr = a;
  endtask

  // Press and hold a key until the probe is idle again, then release.
  task automatic run_press(input bit back);
    @(posedge clk); #1;
    if (back) key_back = 0; else key_fwd = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
    n_tot++;
    if (busy !== 1'b0) $display("FAIL press_done busy=%0b want 0 after bound", busy);
    else n_pass++;
    key_fwd = 1; key_back = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    addr_init = 32'h100;
    #3 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tot++; if (bus.rd_req !== 1'b0) $display("FAIL rst_req got %0b want 0", bus.rd_req); else n_pass++;
    n_tot++; if (bus.rd_addr !== 32'h100) $display("FAIL rst_addr got %h want 00000100", bus.rd_addr); else n_pass++;
    n_tot++; if (dout !== 32'h0) $display("FAIL rst_dout got %h want 0", dout); else n_pass++;
    n_tot++; if ({dout_valid, busy, timeout_err} !== 3'b000)
      $display("FAIL rst_flags got %b want 000", {dout_valid, busy, timeout_err}); else n_pass++;
    n_tot++; if (rd_count !== 16'd0) $display("FAIL rst_count got %0d want 0", rd_count); else n_pass++;
    reset = 1;
    m_addr = 32'h100; m_dout = 0; m_count = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int dv0, seen;
    clear_logs(); dv0 = dv_cnt;
    mode = 0; lat = 5; resp_fixed = 1; fixed_data = 32'hDEADBEEF;
    @(posedge clk); #1 key_fwd = 0;          // first sampled low at edge k
    repeat (2) @(posedge clk);
    #1;                                      // after edge k+1
    n_tot++; if (bus.rd_req !== 1'b0) $display("FAIL single_req_early got %0b want 0", bus.rd_req); else n_pass++;
    @(posedge clk); #1;                      // after edge k+2
    n_tot++; if (bus.rd_req !== 1'b1) $display("FAIL single_req_k2 got %0b want 1", bus.rd_req); else n_pass++;
    n_tot++; if (bus.rd_addr !== 32'h100) $display("FAIL single_addr got %h want 00000100", bus.rd_addr); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (dout_valid === 1'b1) seen = 1;
    end
    n_tot++; if (!seen) $display("FAIL single_dv got none want pulse within 40 cycles"); else n_pass++;
    n_tot++; if (dout !== 32'hDEADBEEF) $display("FAIL single_dout got %h want deadbeef", dout); else n_pass++;
    n_tot++; if (bus.rd_addr !== 32'h104) $display("FAIL single_next_addr got %h want 00000104", bus.rd_addr); else n_pass++;
    n_tot++; if (rd_count !== 16'd1) $display("FAIL single_count got %0d want 1", rd_count); else n_pass++;
    repeat (4) @(posedge clk);
    #1 key_fwd = 1;
    repeat (4) @(posedge clk);
    #1;
    n_tot++; if (dv_cnt - dv0 != 1 || req_log.size() != 1)
      $display("FAIL single_once got dv=%0d req=%0d want 1 1", dv_cnt - dv0, req_log.size()); else n_pass++;
    resp_fixed = 0;
    m_addr = 32'h104; m_dout = 32'hDEADBEEF; m_count = 1;
  endtask

  task automatic test_burst();
    int dv0;
    load_addr(32'h200);
    clear_logs(); dv0 = dv_cnt;
    mode = 1; lat = 2; xor_key = 0;
    run_press(0);
    n_tot++; if (req_log.size() != BLEN) $display("FAIL burst_nreq got %0d want %0d", req_log.size(), BLEN); else n_pass++;
    for (int i = 0; i < BLEN && i < req_log.size(); i++) begin
      n_tot++; if (req_log[i] !== 32'h200 + 32'(4 * i))
        $display("FAIL burst_addr%0d got %h want %h", i, req_log[i], 32'h200 + 32'(4 * i)); else n_pass++;
      if (i > 0) begin
        n_tot++; if (gap_log[i] != 1) $display("FAIL burst_gap%0d got %0d want 1", i, gap_log[i]); else n_pass++;
      end
    end
    m_addr = 32'h210; m_dout = 32'h20C; m_count += BLEN;
    n_tot++; if (dout !== m_dout) $display("FAIL burst_dout got %h want %h", dout, m_dout); else n_pass++;
    n_tot++; if (bus.rd_addr !== m_addr) $display("FAIL burst_next got %h want %h", bus.rd_addr, m_addr); else n_pass++;
    n_tot++; if (rd_count32 !== 32'(m_count)) $display("FAIL burst_count got %0d want %0d", rd_count, m_count); else n_pass++;
    n_tot++; if (dv_cnt - dv0 != BLEN) $display("FAIL burst_dv got %0d want %0d", dv_cnt - dv0, BLEN); else n_pass++;
  endtask

  task automatic test_back_wrap();
    load_addr(32'h0);
    clear_logs();
    run_press(1);
    n_tot++; if (bus.rd_addr !== 32'hFFFF_FFFC) $display("FAIL back_addr got %h want fffffffc", bus.rd_addr); else n_pass++;
    n_tot++; if (req_log.size() != 0) $display("FAIL back_noreq got %0d requests want 0", req_log.size()); else n_pass++;
    mode = 0; lat = 1; xor_key = 32'h5A5A_0000;
    run_press(0);
    n_tot++; if (req_log.size() != 1 || req_log[0] !== 32'hFFFF_FFFC)
      $display("FAIL back_read got n=%0d a=%h want 1 fffffffc", req_log.size(), req_log.size() ? req_log[0] : 32'h0); else n_pass++;
    n_tot++; if (bus.rd_addr !== 32'h0) $display("FAIL back_rewrap got %h want 0", bus.rd_addr); else n_pass++;
    m_addr = 0; m_dout = 32'hFFFF_FFFC ^ xor_key; m_count++;
  endtask

  task automatic test_timeout();
    int dv0;
    clear_logs(); dv0 = dv_cnt;
    mode = 0; resp_off = 1;
    run_press(0);
    n_tot++; if (timeout_err !== 1'b1) $display("FAIL to_err got %0b want 1", timeout_err); else n_pass++;
    n_tot++; if (hi_log.size() != 1 || hi_log[0] != TOUT)
      $display("FAIL to_len got n=%0d len=%0d want %0d", hi_log.size(), hi_log.size() ? hi_log[0] : -1, TOUT); else n_pass++;
    n_tot++; if (bus.rd_addr !== m_addr || dout !== m_dout || rd_count32 !== 32'(m_count) || dv_cnt != dv0)
      $display("FAIL to_hold got a=%h d=%h c=%0d want a=%h d=%h c=%0d", bus.rd_addr, dout, rd_count, m_addr, m_dout, m_count);
    else n_pass++;
    resp_off = 0; lat = 0;
    run_press(0);
    m_dout = m_addr ^ xor_key; m_addr += 4; m_count++;
    n_tot++; if (timeout_err !== 1'b0 || dout !== m_dout)
      $display("FAIL to_fwd_clear got err=%0b d=%h want 0 %h", timeout_err, dout, m_dout); else n_pass++;
    resp_off = 1;
    run_press(0);
    resp_off = 0;
    load_addr(32'h40);
    n_tot++; if (timeout_err !== 1'b0 || bus.rd_addr !== 32'h40)
      $display("FAIL to_load_clear got err=%0b a=%h want 0 00000040", timeout_err, bus.rd_addr); else n_pass++;
  endtask

  task automatic test_random();
    int n, dv0;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1)) load_addr($urandom);
      mode = 1'($urandom_range(0, 1)); lat = $urandom_range(0, 4); xor_key = $urandom;
      n = mode ? BLEN : 1;
      clear_logs(); dv0 = dv_cnt;
      run_press(0);
      n_tot++; if (req_log.size() != n) $display("FAIL rnd%0d_nreq got %0d want %0d", it, req_log.size(), n);
      else begin
        n_pass++;
        for (int i = 0; i < n; i++) begin
          n_tot++; if (req_log[i] !== m_addr + 32'(4 * i))
            $display("FAIL rnd%0d_addr%0d got %h want %h", it, i, req_log[i], m_addr + 32'(4 * i)); else n_pass++;
        end
      end
      m_dout = (m_addr + 32'(4 * (n - 1))) ^ xor_key; m_addr += 32'(4 * n); m_count += n;
      n_tot++; if (dout !== m_dout || bus.rd_addr !== m_addr || rd_count32 !== 32'(m_count) || dv_cnt - dv0 != n)
        $display("FAIL rnd%0d_state got d=%h a=%h c=%0d dv=%0d want d=%h a=%h c=%0d dv=%0d", it,
                 dout, bus.rd_addr, rd_count, dv_cnt - dv0, m_dout, m_addr, m_count, n);
      else n_pass++;
    end
    n_tot++; if (stab_err != 0) $display("FAIL addr_stable got %0d changes want 0", stab_err); else n_pass++;
  endtask

  task automatic test_enable_drop_and_reset();
    int ok;
    clear_logs();
    mode = 1; lat = 3; xor_key = 0;
    @(posedge clk); #1 key_fwd = 0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #3;
      if (req_log.size() == 2) ok = 1;
    end
    enable = 0;
    for (int i = 0; i < 100 && busy; i++) begin @(posedge clk); #1; end
    key_fwd = 1;
    repeat (10) @(posedge clk);
    #1;
    m_dout = m_addr + 4; m_addr += 8; m_count += 2;
    n_tot++; if (!ok || req_log.size() != 2)
      $display("FAIL endrop_nreq got %0d want 2", req_log.size()); else n_pass++;
    n_tot++; if (busy !== 1'b0 || rd_count32 !== 32'(m_count) || dout !== m_dout)
      $display("FAIL endrop_state got busy=%0b c=%0d d=%h want 0 %0d %h", busy, rd_count, dout, m_count, m_dout); else n_pass++;
    enable = 1; resp_off = 1; addr_init = 32'h3000;
    @(posedge clk); #1 key_fwd = 0;
    repeat (5) @(posedge clk);
    #3;
    n_tot++; if (bus.rd_req !== 1'b1) $display("FAIL rstmid_pre got req=%0b want 1", bus.rd_req); else n_pass++;
    reset = 0;
    #1;
    n_tot++; if (bus.rd_req !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_async got req=%0b busy=%0b want 0 0", bus.rd_req, busy); else n_pass++;
    n_tot++; if (bus.rd_addr !== 32'h3000 || dout !== 0 || rd_count !== 0 || timeout_err !== 0 || dout_valid !== 0)
      $display("FAIL rstmid_vals got a=%h d=%h c=%0d e=%0b v=%0b want 00003000 0 0 0 0",
               bus.rd_addr, dout, rd_count, timeout_err, dout_valid); else n_pass++;
    key_fwd = 1; resp_off = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    reset = 1; enable = 1; mode = 0; key_fwd = 1; key_back = 1; addr_load = 0; addr_init = 0;
    test_reset();
    test_single();
    test_burst();
    test_back_wrap();
    test_timeout();
    test_random();
    test_enable_drop_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
